// File: rtl/key_blink_pkg.sv
// Shared encodings for the key hold classifier: event class codes and channel FSM states.
package key_blink_pkg;

    localparam logic [1:0] CLS_SHORT = 2'd0;
    localparam logic [1:0] CLS_MID   = 2'd1;
    localparam logic [1:0] CLS_LONG  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HOLD  = 2'd1,
        ST_BLINK = 2'd2
    } ch_state_t;

endpackage

// File: rtl/key_blink_ch.sv
// One key/LED channel: 2-flop sync, debounce, IDLE/HOLD/BLINK FSM and counters; the event is a
// one-cycle pulse, 2+DEBOUNCE_CYC cycles after the raw release, with no backpressure. KEY_HOLD_IND_EN lights the LED in HOLD from T1_CYC on.
module key_blink_ch
    import key_blink_pkg::*;
#(
    parameter int CNT_W           = 32,
    parameter int DEBOUNCE_CYC    = 1_000_000,
    parameter int T1_CYC          = 50_000_000,
    parameter int T2_CYC          = 100_000_000,
    parameter int HALF_PERIOD_CYC = 25_000_000,
    parameter int BLINKS_SHORT    = 5,
    parameter int BLINKS_MID      = 10,
    parameter int BLINKS_LONG     = 20
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       key_i,
    output logic       led_o,
    output logic       busy_o,
    output logic       ev_valid_o,
    output logic [1:0] ev_class_o
);

    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] T1_V      = CNT_W'(T1_CYC);
    localparam logic [CNT_W-1:0] T2_V      = CNT_W'(T2_CYC);
    localparam logic [CNT_W-1:0] HP_LAST   = CNT_W'(HALF_PERIOD_CYC - 1);
    localparam logic [CNT_W-1:0] TGT_SHORT = CNT_W'(2 * BLINKS_SHORT);
    localparam logic [CNT_W-1:0] TGT_MID   = CNT_W'(2 * BLINKS_MID);
    localparam logic [CNT_W-1:0] TGT_LONG  = CNT_W'(2 * BLINKS_LONG);

    logic             sync1_q, sync2_q;
    logic             db_q, db_d;
    logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
    logic             press_evt, rel_evt;

    ch_state_t        state_q, state_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [CNT_W-1:0] half_cnt_q, half_cnt_d;
    logic [CNT_W-1:0] tgl_cnt_q, tgl_cnt_d;
    logic [CNT_W-1:0] target_q, target_d;
    logic             led_q, led_d;
    logic             ev_valid_q, ev_valid_d;
    logic [1:0]       ev_class_q, ev_class_d;

    logic [CNT_W-1:0] hold_inc;
    logic [CNT_W-1:0] tgl_inc;
    logic [1:0]       cls;
    logic [CNT_W-1:0] cls_target;
    logic             hold_ind;

    // Debounce: any cycle where the synced level matches the accepted level restarts the count.
    always_comb begin
        db_d     = db_q;
        db_cnt_d = '0;
        if (sync2_q != db_q) begin
            if (db_cnt_q == DB_LAST) begin
                db_d = sync2_q;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
    end

    assign press_evt = db_d & ~db_q;
    assign rel_evt   = ~db_d & db_q;

    // Classification counts the current cycle too, so a debounced hold of N cycles classifies as N.
    assign hold_inc = (hold_cnt_q >= T2_V) ? T2_V : hold_cnt_q + 1'b1;
    assign tgl_inc  = tgl_cnt_q + 1'b1;

    always_comb begin
        if (hold_inc >= T2_V) begin
            cls        = CLS_LONG;
            cls_target = TGT_LONG;
        end else if (hold_inc >= T1_V) begin
            cls        = CLS_MID;
            cls_target = TGT_MID;
        end else begin
            cls        = CLS_SHORT;
            cls_target = TGT_SHORT;
        end
    end

`ifdef KEY_HOLD_IND_EN
    assign hold_ind = (hold_inc >= T1_V);
`else
    assign hold_ind = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        half_cnt_d = half_cnt_q;
        tgl_cnt_d  = tgl_cnt_q;
        target_d   = target_q;
        led_d      = led_q;
        ev_valid_d = 1'b0;
        ev_class_d = ev_class_q;

        unique case (state_q)
            ST_IDLE: begin
                led_d = 1'b0;
                if (press_evt) begin
                    state_d    = ST_HOLD;
                    hold_cnt_d = '0;
                end
            end
            ST_HOLD: begin
                hold_cnt_d = hold_inc;
                led_d      = hold_ind;
                if (rel_evt) begin
                    state_d    = ST_BLINK;
                    ev_valid_d = 1'b1;
                    ev_class_d = cls;
                    target_d   = cls_target;
                    half_cnt_d = '0;
                    tgl_cnt_d  = '0;
                    led_d      = 1'b0;
                end
            end
            ST_BLINK: begin
                if (press_evt) begin
                    state_d    = ST_HOLD;
                    hold_cnt_d = '0;
                    led_d      = 1'b0;
                end else if (half_cnt_q == HP_LAST) begin
                    half_cnt_d = '0;
                    led_d      = ~led_q;
                    tgl_cnt_d  = tgl_inc;
                    // Target is even, so the final toggle leaves the LED dark as we return to IDLE.
                    if (tgl_inc == target_q) begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    half_cnt_d = half_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                led_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            db_q       <= 1'b0;
            db_cnt_q   <= '0;
            state_q    <= ST_IDLE;
            hold_cnt_q <= '0;
            half_cnt_q <= '0;
            tgl_cnt_q  <= '0;
            target_q   <= '0;
            led_q      <= 1'b0;
            ev_valid_q <= 1'b0;
            ev_class_q <= CLS_SHORT;
        end else begin
            sync1_q    <= key_i;
            sync2_q    <= sync1_q;
            db_q       <= db_d;
            db_cnt_q   <= db_cnt_d;
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            half_cnt_q <= half_cnt_d;
            tgl_cnt_q  <= tgl_cnt_d;
            target_q   <= target_d;
            led_q      <= led_d;
            ev_valid_q <= ev_valid_d;
            ev_class_q <= ev_class_d;
        end
    end

    assign led_o      = led_q;
    assign busy_o     = (state_q != ST_IDLE);
    assign ev_valid_o = ev_valid_q;
    assign ev_class_o = ev_class_q;

endmodule

// File: rtl/key_hold_blinker.sv
// Multi-channel key hold classifier with LED blink feedback; NUM_CH independent key_blink_ch slices.
// Events fire 2+DEBOUNCE_CYC cycles after raw release, no backpressure; KEY_HOLD_IND_EN adds a HOLD-phase LED indication.
module key_hold_blinker #(
    parameter int NUM_CH          = 2,
    parameter int CNT_W           = 32,
    parameter int DEBOUNCE_CYC    = 1_000_000,
    parameter int T1_CYC          = 50_000_000,
    parameter int T2_CYC          = 100_000_000,
    parameter int HALF_PERIOD_CYC = 25_000_000,
    parameter int BLINKS_SHORT    = 5,
    parameter int BLINKS_MID      = 10,
    parameter int BLINKS_LONG     = 20
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_CH-1:0]     key_in,
    output logic [NUM_CH-1:0]     led_out,
    output logic [NUM_CH-1:0]     busy,
    output logic [NUM_CH-1:0]     ev_valid,
    output logic [2*NUM_CH-1:0]   ev_class
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        key_blink_ch #(
            .CNT_W           (CNT_W),
            .DEBOUNCE_CYC    (DEBOUNCE_CYC),
            .T1_CYC          (T1_CYC),
            .T2_CYC          (T2_CYC),
            .HALF_PERIOD_CYC (HALF_PERIOD_CYC),
            .BLINKS_SHORT    (BLINKS_SHORT),
            .BLINKS_MID      (BLINKS_MID),
            .BLINKS_LONG     (BLINKS_LONG)
        ) u_ch (
            .clk_i      (clk),
            .rst_i      (rst),
            .key_i      (key_in[i]),
            .led_o      (led_out[i]),
            .busy_o     (busy[i]),
            .ev_valid_o (ev_valid[i]),
            .ev_class_o (ev_class[2*i +: 2])
        );
    end

endmodule

// File: tb/tb_key_hold_blinker.sv
// Scoreboard bench: stimulus pushes expected events (class, cycle, blink count); a monitor checks them.
module tb_key_hold_blinker;

    localparam int NCH = 2;
    localparam int D   = 4;
    localparam int T1  = 20;
    localparam int T2  = 40;
    localparam int HP  = 3;
    localparam int BS  = 1;
    localparam int BM  = 2;
    localparam int BL  = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             k0  = 1'b0;
    logic             k1  = 1'b0;
    logic [NCH-1:0]   key_in;
    logic [NCH-1:0]   led_out, busy, ev_valid;
    logic [2*NCH-1:0] ev_class;

    assign key_in = {k1, k0};

    key_hold_blinker #(
        .NUM_CH(NCH), .CNT_W(32), .DEBOUNCE_CYC(D), .T1_CYC(T1), .T2_CYC(T2),
        .HALF_PERIOD_CYC(HP), .BLINKS_SHORT(BS), .BLINKS_MID(BM), .BLINKS_LONG(BL)
    ) dut (
        .clk(clk), .rst(rst), .key_in(key_in), .led_out(led_out),
        .busy(busy), .ev_valid(ev_valid), .ev_class(ev_class)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int cls;
        int ev_cyc;
        int target;
        bit abort;
    } exp_t;

    exp_t exp_q[NCH][$];

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic int cls_of(input int n);
        if (n >= T2) return 2;
        if (n >= T1) return 1;
        return 0;
    endfunction

    function automatic int tgt_of(input int c);
        return 2 * ((c == 2) ? BL : (c == 1) ? BM : BS);
    endfunction

    task automatic set_key(input int ch, input logic v);
        if (ch == 0) k0 = v;
        else k1 = v;
    endtask

    // Raw key held for n sampled cycles; the debounced hold is also n cycles, delayed 2+D.
    task automatic press(input int ch, input int n, input bit abort_next, output int ev_c);
        set_key(ch, 1'b1);
        repeat (n) @(negedge clk);
        set_key(ch, 1'b0);
        ev_c = cyc + 2 + D;
        exp_q[ch].push_back('{cls_of(n), ev_c, tgt_of(cls_of(n)), abort_next});
    endtask

    task automatic wait_idle(input int ch);
        int t;
        t = 0;
        while ((exp_q[ch].size() != 0 || busy[ch]) && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 1000) begin
            checks++;
            errors++;
            $display("FAIL wait_idle ch%0d: still busy after %0d cycles, expected idle", ch, t);
        end
        @(negedge clk);
    endtask

    task automatic rand_ch(input int ch, input int n_iter);
        int e, n;
        int pick[4];
        pick = '{T1 - 1, T1, T2 - 1, T2};
        repeat (n_iter) begin
            if ($urandom_range(3, 0) == 0) n = pick[$urandom_range(3, 0)];
            else n = $urandom_range(60, D);
            press(ch, n, 1'b0, e);
            wait_idle(ch);
            repeat ($urandom_range(4, 0)) @(negedge clk);
        end
    endtask

    // Monitor
    int             blink_start[NCH];
    int             tgt[NCH];
    int             tgl_seen[NCH];
    int             last_tgl[NCH];
    bit             blinking[NCH];
    bit             abort_pend[NCH];
    logic [NCH-1:0] prev_led = '0;
    logic [NCH-1:0] prev_ev  = '0;
    exp_t           e_mon;

    always @(negedge clk) begin
        if (rst) begin
            for (int ch = 0; ch < NCH; ch++) begin
                blinking[ch]   = 1'b0;
                abort_pend[ch] = 1'b0;
                exp_q[ch].delete();
            end
            prev_led = '0;
            prev_ev  = '0;
        end else begin
            for (int ch = 0; ch < NCH; ch++) begin
                if (ev_valid[ch]) begin
                    if (prev_ev[ch]) check("ev_back_to_back", 1, 0);
                    if (exp_q[ch].size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL ev_unexpected ch%0d: got event class %0d, expected none (cycle %0d)",
                                 ch, ev_class[2*ch +: 2], cyc);
                    end else begin
                        e_mon = exp_q[ch].pop_front();
                        check("ev_class", int'(ev_class[2*ch +: 2]), e_mon.cls);
                        check("ev_cycle", cyc, e_mon.ev_cyc);
                        check("ev_led_off", int'(led_out[ch]), 0);
                        blinking[ch]    = 1'b1;
                        abort_pend[ch]  = e_mon.abort;
                        tgt[ch]         = e_mon.target;
                        tgl_seen[ch]    = 0;
                        last_tgl[ch]    = cyc;
                        blink_start[ch] = cyc;
                    end
                end else if (blinking[ch]) begin
                    if (led_out[ch] != prev_led[ch]) begin
                        if (abort_pend[ch] && !led_out[ch] && (cyc - last_tgl[ch]) != HP) begin
                            blinking[ch] = 1'b0;
                            check("abort_still_busy", int'(busy[ch]), 1);
                        end else begin
                            tgl_seen[ch]++;
                            check("tgl_spacing", cyc - last_tgl[ch], HP);
                            last_tgl[ch] = cyc;
                        end
                    end
                    if (blinking[ch] && !busy[ch]) begin
                        check("tgl_count", tgl_seen[ch], tgt[ch]);
                        check("blink_len", cyc - blink_start[ch], tgt[ch] * HP);
                        check("led_after_blink", int'(led_out[ch]), 0);
                        blinking[ch] = 1'b0;
                    end
                end
            end
            prev_ev  = ev_valid;
            prev_led = led_out;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int r, r2;
        logic busy_seen;

        repeat (3) @(negedge clk);
        check("rst_led", int'(led_out), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_ev_valid", int'(ev_valid), 0);
        check("rst_ev_class", int'(ev_class), 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        press(0, 10, 1'b0, r);   wait_idle(0);
        press(0, 20, 1'b0, r);   wait_idle(0);
        press(0, 19, 1'b0, r);   wait_idle(0);

        fork
            press(1, 100, 1'b0, r);
            begin
                repeat (50) @(negedge clk);
                check("ch0_idle_led", int'(led_out[0]), 0);
                check("ch0_idle_busy", int'(busy[0]), 0);
            end
            begin
                repeat (2 + D + T1 - 1) @(negedge clk);
                check("hold_ind_before_t1", int'(led_out[1]), 0);
                @(negedge clk);
`ifdef KEY_HOLD_IND_EN
                check("hold_ind_on", int'(led_out[1]), 1);
`else
                check("hold_led_off", int'(led_out[1]), 0);
`endif
            end
        join
        wait_idle(1);

        busy_seen = 1'b0;
        fork
            begin
                repeat (3) begin
                    k0 = 1'b1;
                    repeat (2) @(negedge clk);
                    k0 = 1'b0;
                    repeat (4) @(negedge clk);
                end
                repeat (10) @(negedge clk);
            end
            repeat (30) begin
                @(negedge clk);
                busy_seen = busy_seen | busy[0];
            end
        join
        check("glitch_busy", int'(busy_seen), 0);

        // Re-press so the new press is accepted one cycle after the first blink toggle.
        press(0, 10, 1'b1, r);
        repeat (4) @(negedge clk);
        fork
            press(0, 12, 1'b0, r2);
            begin
                repeat (5) @(negedge clk);
                check("first_toggle_led", int'(led_out[0]), 1);
                @(negedge clk);
                check("abort_led", int'(led_out[0]), 0);
                check("abort_busy", int'(busy[0]), 1);
            end
        join
        wait_idle(0);

        press(0, 20, 1'b0, r);
        repeat (10) @(negedge clk);
        check("pre_reset_led", int'(led_out[0]), 1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_blink_led", int'(led_out), 0);
        check("rst_blink_busy", int'(busy), 0);
        check("rst_blink_ev", int'(ev_valid), 0);
        check("rst_blink_class", int'(ev_class), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        k0 = 1'b1;
        repeat (2 + D + 10) @(negedge clk);
        check("pre_reset_hold_busy", int'(busy[0]), 1);
        rst = 1'b1;
        k0  = 1'b0;
        @(negedge clk);
        check("rst_hold_busy", int'(busy), 0);
        check("rst_hold_led", int'(led_out), 0);
        check("rst_hold_ev", int'(ev_valid), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("post_reset_idle", int'(busy[0]), 0);

        fork
            rand_ch(0, 8);
            rand_ch(1, 8);
        join

        wait_idle(0);
        wait_idle(1);
        check("q0_drained", exp_q[0].size(), 0);
        check("q1_drained", exp_q[1].size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/key_hold_blinker.md
Name: key_hold_blinker

Overview:
Multi-channel push-key hold-duration classifier with LED blink feedback. Per channel: synchronise and debounce a raw key. Measure how long the key is held. On release, classify the hold as SHORT, MID or LONG. Emit a one-cycle event and blink that channel's LED a class-dependent number of times. Sits between board push-keys and LED pins; the event outputs also feed downstream control logic.

Parameters:
NUM_CH, 2, number of independent key/LED channels
CNT_W, 32, width of all internal cycle counters
DEBOUNCE_CYC, 1_000_000, consecutive stable cycles required to accept a key level change
T1_CYC, 50_000_000, hold cycles at/above which class is MID
T2_CYC, 100_000_000, hold cycles at/above which class is LONG (T2_CYC > T1_CYC)
HALF_PERIOD_CYC, 25_000_000, cycles between LED toggles
BLINKS_SHORT, 5, full on/off blinks for SHORT
BLINKS_MID, 10, full blinks for MID
BLINKS_LONG, 20, full blinks for LONG

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
key_in  in  NUM_CH  raw asynchronous keys, active-high (1 = pressed)
led_out  out  NUM_CH  LED drive, 1 = lit
busy  out  NUM_CH  channel is in HOLD or BLINK
ev_valid  out  NUM_CH  one-cycle pulse when a hold is classified
ev_class  out  2*NUM_CH  class per channel, bits [2i+1:2i]: 0 SHORT, 1 MID, 2 LONG; held from pulse until next event

Behaviour:
- Reset:
  - Applied on rising clk while rst=1.
  - All outputs 0.
  - All counters 0.
  - Synchronisers cleared.
  - All channels to IDLE.
  - Reset mid-HOLD or mid-BLINK aborts with no event; led_out is 0 at the next edge.
- Input path, per channel:
  - 2-flop synchroniser feeds the debouncer.
  - Debounced level changes only after DEBOUNCE_CYC consecutive cycles of the synchronised input differing from the current debounced level.
  - Any glitch restarts the debounce count.
  - Raw edge to state reaction latency: 2 + DEBOUNCE_CYC cycles.
- Channels are fully independent. No shared state besides clk/rst.
- IDLE:
  - led=0, busy=0.
  - Debounced press: go to HOLD, hold_cnt=0.
- HOLD:
  - busy=1, led=0.
  - hold_cnt increments each cycle, saturating at T2_CYC (never wraps).
  - On debounced release, classify on the final hold_cnt:
    - hold_cnt >= T2_CYC: LONG
    - else hold_cnt >= T1_CYC: MID
    - else SHORT
  - Exact equality with a threshold selects the higher class.
  - On the same edge: ev_valid=1 for one cycle, ev_class updated, and state goes to BLINK with tgl_cnt=0, half_cnt=0, target = 2*BLINKS_x.
- BLINK:
  - busy=1.
  - half_cnt counts 0..HALF_PERIOD_CYC-1. At terminal count: led toggles, half_cnt=0, tgl_cnt++.
  - First toggle (led to 1) occurs HALF_PERIOD_CYC cycles after entry.
  - When tgl_cnt == target, go to IDLE. led is 0 then because target is even.
- Press during BLINK (new press on a debounced edge): abort the blink, led=0, go to HOLD with hold_cnt=0. No event for the aborted blink.
- ev_valid is never asserted in consecutive cycles on one channel.

Optional Feature:
KEY_HOLD_IND_EN:
- Defined: in HOLD, led_out=1 while hold_cnt >= T1_CYC. This gives the user live feedback that MID is reached. Exit from HOLD still forces led=0 before BLINK starts.
- Undefined: led_out=0 throughout HOLD, as above.

Decomposition:
- Shared package key_blink_pkg:
  - Class encoding constants CLS_SHORT/CLS_MID/CLS_LONG (2-bit).
  - Channel state encoding ST_IDLE/ST_HOLD/ST_BLINK.
- Sub-module key_blink_ch (one channel: synchroniser, debouncer, FSM, counters). It takes the same timing parameters and is instantiated NUM_CH times in a generate loop by key_hold_blinker.

Test Plan:
Use DEBOUNCE_CYC=4, T1_CYC=20, T2_CYC=40, HALF_PERIOD_CYC=3, BLINKS 1/2/4, NUM_CH=2.
- Hold ch0 for 10 debounced cycles -> ev_valid pulse, class 0, exactly 2 led toggles (3 cycles apart), then busy=0, led=0.
- Hold ch0 for exactly 20 cycles -> class 1 (MID), 4 toggles; 19 cycles -> class 0.
- Hold ch1 for 100 cycles -> class 2, 8 toggles; hold_cnt saturates at 40, no wrap; ch0 stays idle, led_out[0]=0.
- 2-cycle glitches on key_in[0] while idle -> no HOLD, busy stays 0, no event.
- Press again during BLINK after the 1st toggle -> led=0 next edge, HOLD restarts, the new release yields a fresh event.
- Assert rst mid-BLINK and mid-HOLD -> all outputs 0 next edge, no ev_valid; with KEY_HOLD_IND_EN defined, led=1 from hold cycle 20 until release.
